fifo_flagged: RTL and testbench

- Parametrised successor to the team's synchronous single-clock FIFO.
- Adds these features to the basic FIFO:
  - Selectable standard or first-word-fall-through (FWFT) read mode.
  - Fill-level output.
  - Programmable almost-full and almost-empty flags.
  - Sticky overflow and underflow error flags.
  - Synchronous flush.
- Sits between streaming producers and consumers (sample buffers, UART/SPI paths). Storage is inferred memory, so it maps to iCE40 block RAM.

---
 rtl/fifo_flagged.sv | 159 +++++++++++++++
 tb/tb_fifo_flagged.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_flagged.sv
// Synchronous single-clock FIFO with fill level, programmable almost-full /
// almost-empty flags, sticky overflow/underflow errors, synchronous flush and
// a choice of standard (registered read) or first-word-fall-through output.
// Storage is a plain array read into a register, so it maps onto block RAM.
module fifo_flagged #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 10,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LVL_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     data_out,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic [LVL_WIDTH-1:0] level,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [LVL_WIDTH-1:0]  LVL_FULL  = LVL_WIDTH'(DEPTH);
  localparam logic [LVL_WIDTH-1:0]  AF_LVL    = LVL_WIDTH'(AF_THRESH);
  localparam logic [LVL_WIDTH-1:0]  AE_LVL    = LVL_WIDTH'(AE_THRESH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [LVL_WIDTH-1:0]  level_q;
  logic [LVL_WIDTH-1:0]  level_d;
  logic                  valid_q;   // FWFT output register holds a word
  logic [WIDTH-1:0]      data_q;
  logic                  overflow_q;
  logic                  underflow_q;

  logic wr_ok;
  logic rd_ok;
  logic mem_avail;   // at least one word sits in memory (not in the output reg)
  logic mem_rd;      // fetch mem[rd_addr] into the output register this edge
  logic ovf_set;
  logic unf_set;

  // Flags are pure decodes of registered state, so they show the post-edge view.
  assign full         = (level_q == LVL_FULL);
  assign empty        = (FWFT != 0) ? !valid_q : (level_q == '0);
  assign almost_empty = (level_q <= AE_LVL);
  assign almost_full  = (level_q >= AF_LVL);
  assign level        = level_q;
  assign data_out     = data_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Accept/fetch decisions and next fill level, all from pre-edge flags.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    wr_ok     = wr_en && !full && !flush;
    rd_ok     = rd_en && !empty && !flush;
    mem_avail = (level_q != LVL_WIDTH'(valid_q));
    mem_rd    = rd_ok;
    ovf_set   = wr_en && full && !flush;
    unf_set   = rd_en && empty && !flush;
    level_d   = level_q;

    if (FWFT != 0) begin
      // Refill the output register whenever it is (or is about to be) free.
      mem_rd = (!valid_q || rd_ok) && mem_avail && !flush;
    end

    if (flush) begin
      level_d = '0;
    end else if (wr_ok && !rd_ok) begin
      level_d = level_q + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      level_d = level_q - 1'b1;
    end
  end

  // Storage array: written only on an accepted write.
  // NOTE: the memory has no reset; clearing it would stop block-RAM inference,
  // and stale contents are unreachable because pointers and level are reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= data_in;
    end
  end

  // Pointers, level and the FWFT valid bit.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_addr <= '0;
      rd_addr <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
    end else begin
      level_q <= level_d;
      if (flush) begin
        wr_addr <= '0;
        rd_addr <= '0;
        valid_q <= 1'b0;
      end else begin
        if (wr_ok) begin
          wr_addr <= (wr_addr == ADDR_LAST) ? '0 : wr_addr + 1'b1;
        end
        if (mem_rd) begin
          rd_addr <= (rd_addr == ADDR_LAST) ? '0 : rd_addr + 1'b1;
        end
        if (FWFT != 0) begin
          if (mem_rd) begin
            valid_q <= 1'b1;
          end else if (rd_ok) begin
            valid_q <= 1'b0;
          end
        end
      end
    end
  end

  // Output data register: loads on a fetch, holds otherwise (also across flush).
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      data_q <= '0;
    end else if (mem_rd) begin
      data_q <= mem[rd_addr];
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins over clr_err.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end else if (clr_err) begin
        overflow_q <= 1'b0;
      end
      if (unf_set) begin
        underflow_q <= 1'b1;
      end else if (clr_err) begin
        underflow_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_flagged.sv
// Directed table-driven bench for fifo_flagged: one standard-mode and one
// FWFT instance (DEPTH=10, AF=9, AE=1), plus a hand-written async-reset sequence.
module tb_fifo_flagged;

  localparam int W  = 8;
  localparam int D  = 10;
  localparam int LW = 4;

  typedef struct packed {
    logic [W-1:0]  dout;
    logic          empty;
    logic          full;
    logic          ae;
    logic          af;
    logic [LW-1:0] lvl;
    logic          ovf;
    logic          unf;
  } out_t;

  typedef struct {
    string        name;
    bit           sel;    // 0: standard instance, 1: FWFT instance
    logic         fl;
    logic         we;
    logic         re;
    logic         ce;
    logic [W-1:0] din;
    out_t         exp;
  } vec_t;

  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  logic          s_flush, s_wr, s_rd, s_clr;
  logic [W-1:0]  s_din, s_dout;
  logic          s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
  logic [LW-1:0] s_lvl;
  logic          f_flush, f_wr, f_rd, f_clr;
  logic [W-1:0]  f_din, f_dout;
  logic          f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
  logic [LW-1:0] f_lvl;
  out_t          s_out, f_out;

  assign s_out = {s_dout, s_empty, s_full, s_ae, s_af, s_lvl, s_ovf, s_unf};
  assign f_out = {f_dout, f_empty, f_full, f_ae, f_af, f_lvl, f_ovf, f_unf};

  fifo_flagged #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AF_THRESH(9), .AE_THRESH(1)) u_std (
    .clk(clk), .n_reset(n_reset), .flush(s_flush), .data_in(s_din),
    .wr_en(s_wr), .rd_en(s_rd), .clr_err(s_clr), .data_out(s_dout),
    .empty(s_empty), .full(s_full), .almost_empty(s_ae), .almost_full(s_af),
    .level(s_lvl), .overflow(s_ovf), .underflow(s_unf)
  );

  fifo_flagged #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AF_THRESH(9), .AE_THRESH(1)) u_fwft (
    .clk(clk), .n_reset(n_reset), .flush(f_flush), .data_in(f_din),
    .wr_en(f_wr), .rd_en(f_rd), .clr_err(f_clr), .data_out(f_dout),
    .empty(f_empty), .full(f_full), .almost_empty(f_ae), .almost_full(f_af),
    .level(f_lvl), .overflow(f_ovf), .underflow(f_unf)
  );

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Expected outputs from data, level, empty and error bits (DEPTH=10, AF=9, AE=1).
  function automatic out_t ex(input logic [W-1:0] d, input int lvl, input logic emp,
                              input logic ovf, input logic unf);
    out_t o;
    o.dout  = d;
    o.empty = emp;
    o.full  = (lvl == D);
    o.ae    = (lvl <= 1);
    o.af    = (lvl >= 9);
    o.lvl   = LW'(lvl);
    o.ovf   = ovf;
    o.unf   = unf;
    return o;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("dout=%h empty=%b full=%b ae=%b af=%b level=%0d ovf=%b unf=%b",
                     o.dout, o.empty, o.full, o.ae, o.af, o.lvl, o.ovf, o.unf);
  endfunction

  task automatic add(input string nm, input bit sel, input logic fl, input logic we,
                     input logic re, input logic ce, input logic [W-1:0] din, input out_t e);
    vec_t v;
    v.name = nm; v.sel = sel; v.fl = fl; v.we = we; v.re = re; v.ce = ce;
    v.din = din; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input out_t act, input out_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {%s} expected {%s}", nm, fmt(act), fmt(exp));
    end
  endtask

  task automatic idle_inputs();
    s_flush = 0; s_wr = 0; s_rd = 0; s_clr = 0; s_din = '0;
    f_flush = 0; f_wr = 0; f_rd = 0; f_clr = 0; f_din = '0;
  endtask

  // Drive one vector, clock it, compare 1 time unit after the edge.
  task automatic apply(input vec_t v);
    idle_inputs();
    if (v.sel) begin
      f_flush = v.fl; f_wr = v.we; f_rd = v.re; f_clr = v.ce; f_din = v.din;
    end else begin
      s_flush = v.fl; s_wr = v.we; s_rd = v.re; s_clr = v.ce; s_din = v.din;
    end
    @(posedge clk);
    #1;
    check(v.name, v.sel ? f_out : s_out, v.exp);
  endtask

  task automatic build_table();
    // Standard mode: fill to full, drain in order.
    for (int i = 1; i <= 10; i++)
      add($sformatf("t1_wr%0d", i), 0, 0, 1, 0, 0, W'(i), ex(8'h00, i, 0, 0, 0));
    for (int j = 1; j <= 10; j++)
      add($sformatf("t1_rd%0d", j), 0, 0, 0, 1, 0, 8'h00, ex(W'(j), 10 - j, j == 10, 0, 0));
    // Write while full with a simultaneous read: write dropped, overflow set.
    for (int i = 0; i < 10; i++)
      add($sformatf("t2_fill%0d", i), 0, 0, 1, 0, 0, W'(8'h11 + i), ex(8'h0A, i + 1, 0, 0, 0));
    add("t2_wr_rd_full", 0, 0, 1, 1, 0, 8'hEE, ex(8'h11, 9, 0, 1, 0));
    add("t2_clr_err",    0, 0, 0, 0, 1, 8'h00, ex(8'h11, 9, 0, 0, 0));
    for (int j = 0; j < 9; j++)
      add($sformatf("t2_drain%0d", j), 0, 0, 0, 1, 0, 8'h00, ex(W'(8'h12 + j), 8 - j, j == 8, 0, 0));
    // Pointer wrap: 25 write/read pairs.
    for (int k = 0; k < 25; k++) begin
      add($sformatf("t4_wr%0d", k), 0, 0, 1, 0, 0, W'(8'h40 + k),
          ex((k == 0) ? 8'h1A : W'(8'h40 + k - 1), 1, 0, 0, 0));
      add($sformatf("t4_rd%0d", k), 0, 0, 0, 1, 0, 8'h00, ex(W'(8'h40 + k), 0, 1, 0, 0));
    end
    // Underflow: sticky, set beats clear, clear works.
    add("t5_rd_empty",  0, 0, 0, 1, 0, 8'h00, ex(8'h58, 0, 1, 0, 1));
    add("t5_set_wins",  0, 0, 0, 1, 1, 8'h00, ex(8'h58, 0, 1, 0, 1));
    add("t5_clr",       0, 0, 0, 0, 1, 8'h00, ex(8'h58, 0, 1, 0, 0));
    add("t5_rd_empty2", 0, 0, 0, 1, 0, 8'h00, ex(8'h58, 0, 1, 0, 1));
    // Flush at level 6 with wr_en/rd_en high.
    for (int i = 0; i < 6; i++)
      add($sformatf("t5_wr%0d", i), 0, 0, 1, 0, 0, W'(8'h60 + i), ex(8'h58, i + 1, 0, 0, 1));
    add("t5_flush",    0, 1, 1, 1, 0, 8'h99, ex(8'h58, 0, 1, 0, 1));
    add("t5_wr_after", 0, 0, 1, 0, 0, 8'h77, ex(8'h58, 1, 0, 0, 1));
    add("t5_rd_after", 0, 0, 0, 1, 0, 8'h00, ex(8'h77, 0, 1, 0, 1));

    // FWFT: first word appears one edge after the write edge.
    add("t3_wr55", 1, 0, 1, 0, 0, 8'h55, ex(8'h00, 1, 1, 0, 0));
    add("t3_wr10", 1, 0, 1, 0, 0, 8'h10, ex(8'h55, 2, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      add($sformatf("t3_stream%0d", k), 1, 0, 1, 1, 0, W'(8'h11 + k), ex(W'(8'h10 + k), 2, 0, 0, 0));
    add("t3_pop17",     1, 0, 0, 1, 0, 8'h00, ex(8'h18, 1, 0, 0, 0));
    add("t3_pop18",     1, 0, 0, 1, 0, 8'h00, ex(8'h18, 0, 1, 0, 0));
    add("t3_rd_empty",  1, 0, 0, 1, 0, 8'h00, ex(8'h18, 0, 1, 0, 1));
    add("t3_clr",       1, 0, 0, 0, 1, 8'h00, ex(8'h18, 0, 1, 0, 0));
    // FWFT capacity counts the output register: full at 10 words total.
    for (int i = 0; i < 10; i++)
      add($sformatf("t3_fill%0d", i), 1, 0, 1, 0, 0, W'(8'hA0 + i),
          ex((i == 0) ? 8'h18 : 8'hA0, i + 1, i == 0, 0, 0));
    add("t3_wr_full",   1, 0, 1, 0, 0, 8'hBB, ex(8'hA0, 10, 0, 1, 0));
    add("t3_hold",      1, 0, 0, 0, 0, 8'h00, ex(8'hA0, 10, 0, 1, 0));
    add("t3_pop_a0",    1, 0, 0, 1, 0, 8'h00, ex(8'hA1, 9, 0, 1, 0));
    add("t3_wr_rd",     1, 0, 1, 1, 0, 8'hC0, ex(8'hA2, 9, 0, 1, 0));
    add("t3_flush",     1, 1, 1, 0, 0, 8'hDD, ex(8'hA2, 0, 1, 1, 0));
  endtask

  initial begin
    idle_inputs();
    n_reset = 1'b0;
    #11;
    check("reset_std",  s_out, ex(8'h00, 0, 1, 0, 0));
    check("reset_fwft", f_out, ex(8'h00, 0, 1, 0, 0));
    #1 n_reset = 1'b1;

    build_table();
    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset mid-burst: level 4 with underflow set.
    for (int i = 0; i < 4; i++) begin
      vec_t v;
      v.name = $sformatf("t6_wr%0d", i); v.sel = 0; v.fl = 0; v.we = 1; v.re = 0;
      v.ce = 0; v.din = W'(8'hD0 + i); v.exp = ex(8'h77, i + 1, 0, 0, 1);
      apply(v);
    end
    idle_inputs();
    s_wr = 1; s_din = 8'hD4;
    #2 n_reset = 1'b0;
    #1;
    check("t6_async_std",  s_out, ex(8'h00, 0, 1, 0, 0));
    check("t6_async_fwft", f_out, ex(8'h00, 0, 1, 0, 0));
    idle_inputs();
    @(negedge clk);
    n_reset = 1'b1;
    begin
      vec_t v;
      v.name = "t6_rd_after_reset"; v.sel = 0; v.fl = 0; v.we = 0; v.re = 1;
      v.ce = 0; v.din = 8'h00; v.exp = ex(8'h00, 0, 1, 0, 1);
      apply(v);
      v.name = "t6_wr_after_reset"; v.we = 1; v.re = 0; v.din = 8'hE1;
      v.exp = ex(8'h00, 1, 0, 0, 1);
      apply(v);
      v.name = "t6_rd_e1"; v.we = 0; v.re = 1; v.din = 8'h00;
      v.exp = ex(8'hE1, 0, 1, 0, 1);
      apply(v);
    end

    idle_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
